// File: rtl/irq_ctrl_pkg.sv
// Shared types and register offsets for the interrupt controller.
package irq_ctrl_pkg;

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam logic [1:0] OFF_PENDING = 2'd0;
    localparam logic [1:0] OFF_MASK    = 2'd1;
    localparam logic [1:0] OFF_ACTIVE  = 2'd2;
    localparam logic [1:0] OFF_CLEAR   = 2'd3;

    localparam int ACTIVE_VALID_BIT = 7;

endpackage

// File: rtl/irq_controller_if.sv
// Bus address/strobe and CPU interrupt handshake between the CPU side (master) and the controller (slave).
interface irq_controller_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       CPU_INTERRUPT_RAISE;
    logic       CPU_INTERRUPT_ACK;

    modport master (output BUS_ADDR, output BUS_WE, output CPU_INTERRUPT_ACK,
                    input  CPU_INTERRUPT_RAISE);
    modport slave  (input  BUS_ADDR, input  BUS_WE, input  CPU_INTERRUPT_ACK,
                    output CPU_INTERRUPT_RAISE);
endinterface

// File: rtl/irq_arbiter.sv
// Combinational selector: first set bit of req & mask searching upward from start, wrapping.
module irq_arbiter #(
    parameter int NUM_SOURCES = 4
) (
    input  logic [NUM_SOURCES-1:0] req,
    input  logic [NUM_SOURCES-1:0] mask,
    input  logic [2:0]             start,
    output logic                   grant_valid,
    output logic [2:0]             grant_id
);
    always_comb begin
        int idx;
        grant_valid = 1'b0;
        grant_id    = 3'd0;
        idx         = 0;
        for (int k = 0; k < NUM_SOURCES; k++) begin
            idx = int'(start) + k;
            if (idx >= NUM_SOURCES) idx = idx - NUM_SOURCES;
            if (!grant_valid && req[idx] && mask[idx]) begin
                grant_valid = 1'b1;
                grant_id    = 3'(idx);
            end
        end
    end
endmodule

// File: rtl/irq_controller.sv
// Edge-capturing interrupt controller with mask and a one-at-a-time CPU handshake.
// Define IRQ_CTRL_ROUND_ROBIN_EN for rotating priority; otherwise lowest index wins.
module irq_controller
    import irq_ctrl_pkg::*;
#(
    parameter int         NUM_SOURCES  = 4,
    parameter logic [7:0] BASE_ADDR    = 8'hE0,
    parameter logic [7:0] INITIAL_MASK = 8'hFF
) (
    input  logic                   CLK,
    input  logic                   RESET,
    irq_controller_if.slave        bus,
    inout  wire  [7:0]             BUS_DATA,
    input  logic [NUM_SOURCES-1:0] IRQ_IN,
    output logic [NUM_SOURCES-1:0] IRQ_ACK_OUT
);
    state_t                 state, state_nxt;
    logic [NUM_SOURCES-1:0] prev, pending, rise, clr, ack_vec;
    logic [7:0]             mask, off, rd_data;
    logic [2:0]             active_id, grant_id, rr_ptr;
    logic [1:0]             rd_sel;
    logic                   grant_valid, in_win, wr_mask, wr_clear, ack_fire, rd_en;

    assign off      = bus.BUS_ADDR - BASE_ADDR;
    assign in_win   = (off < 8'd4);
    assign wr_mask  = in_win && bus.BUS_WE && (off[1:0] == OFF_MASK);
    assign wr_clear = in_win && bus.BUS_WE && (off[1:0] == OFF_CLEAR);
    assign ack_fire = (state == ACTIVE) && bus.CPU_INTERRUPT_ACK;
    assign rise     = IRQ_IN & ~prev;

    always_comb begin
        ack_vec = '0;
        for (int i = 0; i < NUM_SOURCES; i++) ack_vec[i] = (3'(i) == active_id);
    end

    // Clear is applied before set so a same-cycle edge keeps the bit pending.
    assign clr = (wr_clear ? BUS_DATA[NUM_SOURCES-1:0] : '0) | (ack_fire ? ack_vec : '0);

    irq_arbiter #(.NUM_SOURCES(NUM_SOURCES)) u_arb (
        .req         (pending),
        .mask        (mask[NUM_SOURCES-1:0]),
        .start       (rr_ptr),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

`ifdef IRQ_CTRL_ROUND_ROBIN_EN
    always_ff @(posedge CLK) begin
        if (RESET)
            rr_ptr <= 3'd0;
        else if (ack_fire)
            rr_ptr <= (active_id == 3'(NUM_SOURCES - 1)) ? 3'd0 : active_id + 3'd1;
    end
`else
    assign rr_ptr = 3'd0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_valid)           state_nxt = ACTIVE;
            ACTIVE:  if (bus.CPU_INTERRUPT_ACK) state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    assign bus.CPU_INTERRUPT_RAISE = (state == ACTIVE);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev        <= '0;
            pending     <= '0;
            mask        <= INITIAL_MASK;
            active_id   <= 3'd0;
            IRQ_ACK_OUT <= '0;
            rd_en       <= 1'b0;
            rd_sel      <= 2'd0;
        end else begin
            prev        <= IRQ_IN;
            pending     <= (pending & ~clr) | rise;
            if (wr_mask) mask <= BUS_DATA;
            if (state == IDLE && grant_valid) active_id <= grant_id;
            IRQ_ACK_OUT <= ack_fire ? ack_vec : '0;
            rd_en       <= in_win && !bus.BUS_WE && (off[1:0] != OFF_CLEAR);
            rd_sel      <= off[1:0];
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (rd_sel)
            OFF_PENDING: rd_data[NUM_SOURCES-1:0] = pending;
            OFF_MASK:    rd_data = mask;
            OFF_ACTIVE: begin
                rd_data[2:0]             = active_id;
                rd_data[ACTIVE_VALID_BIT] = (state == ACTIVE);
            end
            default:     rd_data = 8'h00;
        endcase
    end

    assign BUS_DATA = rd_en ? rd_data : 8'bz;

endmodule

// File: doc/irq_controller.md
# irq_controller

Memory-mapped interrupt controller between the bus peripherals (timer, mouse, etc.) and the microprocessor's single interrupt input. It edge-detects up to eight peripheral interrupt-raise lines and latches them as pending. It applies a mask and presents one interrupt at a time to the CPU. When the CPU acknowledges, it routes the acknowledge back to the peripheral that raised the interrupt.

## Interface
- NUM_SOURCES, 4: number of interrupt sources, legal range 1..8; source 0 is the timer.
- BASE_ADDR, 8'hE0: base of the 4-byte register window E0..E3, clear of the timer's F0..F3.
- INITIAL_MASK, 8'hFF: mask value loaded at reset; 1 means enabled.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  synchronous, active-high reset.
- BUS_DATA  inout  8  shared data bus; tristated when this block is not driving it.
- BUS_ADDR  in  8  bus address.
- BUS_WE  in  1  bus write enable.
- IRQ_IN  in  NUM_SOURCES  raise lines from the peripherals; each is held high until that peripheral is acknowledged.
- IRQ_ACK_OUT  out  NUM_SOURCES  one-cycle acknowledge pulse to each peripheral.
- CPU_INTERRUPT_RAISE  out  1  interrupt request to the CPU.
- CPU_INTERRUPT_ACK  in  1  acknowledge from the CPU.

## Operation
Register map:
- BASE+0: PENDING, read-only. Bits above NUM_SOURCES read as 0.
- BASE+1: MASK, read/write.
- BASE+2: ACTIVE_ID, read-only. Bit 7 is the valid flag; bits 2:0 hold the source id.
- BASE+3: CLEAR, write-only. Writing a 1 to a bit clears that pending bit.

Edge capture and pending:
- A registered copy of IRQ_IN gives rise[i] = IRQ_IN[i] & ~prev[i].
- rise[i] sets pending[i].
- pending[i] is cleared by a CLEAR write with bit i set, or by the CPU ack while source i is active.
- If a set and a clear hit the same bit in the same cycle, the set wins.

State machine, states IDLE and ACTIVE:
- IDLE: if (pending & MASK) is nonzero, the arbiter selects an id. The id is latched, CPU_INTERRUPT_RAISE goes to 1, and the state moves to ACTIVE.
- ACTIVE: CPU_INTERRUPT_RAISE is held at 1. When CPU_INTERRUPT_ACK is sampled high:
  - IRQ_ACK_OUT[id] pulses for one cycle;
  - pending[id] is cleared;
  - CPU_INTERRUPT_RAISE goes to 0;
  - the state returns to IDLE.
- There is no retraction: changing MASK or writing CLEAR for the active id while in ACTIVE does not drop the raise. The ack still completes normally.
- CPU_INTERRUPT_ACK received in IDLE is ignored.

Bus read:
- The output enable is registered. It asserts in the cycle after BUS_ADDR falls in BASE..BASE+2 with BUS_WE = 0.
- While enabled, the block drives the register selected by the address latched with the enable. Otherwise BUS_DATA is Z.

Reset values:
- CPU_INTERRUPT_RAISE = 0; IRQ_ACK_OUT = 0; pending = 0; prev = 0.
- MASK = INITIAL_MASK; state = IDLE; ACTIVE_ID = 0; BUS_DATA = Z.
- A reset mid-operation abandons the active interrupt and emits no ack.
- Because prev resets to 0, a source still held high after reset is re-captured as a new edge.

## Timing
- IRQ_IN[i] first sampled high at edge k → pending[i] is set after k → CPU_INTERRUPT_RAISE is high after k+1. Raise latency is 2 cycles.
- CPU_INTERRUPT_ACK sampled at edge m → after m, CPU_INTERRUPT_RAISE = 0 and IRQ_ACK_OUT[id] = 1 → after m+1, IRQ_ACK_OUT = 0.
- Minimum spacing between consecutive raises is 1 IDLE cycle.
- Register writes take effect after the write edge. A mask change affects the next arbitration.
- Read data is valid one cycle after the address is presented.

## Configuration
- IRQ_CTRL_ROUND_ROBIN_EN undefined: fixed priority; the lowest enabled pending index wins.
- IRQ_CTRL_ROUND_ROBIN_EN defined: rotating priority.
  - A pointer holds last-serviced id + 1, modulo NUM_SOURCES, and the search starts there.
  - The pointer resets to 0 and is updated on each CPU ack.

## Structure
- Package irq_ctrl_pkg:
  - state enum {IDLE, ACTIVE};
  - register offsets OFF_PENDING = 0, OFF_MASK = 1, OFF_ACTIVE = 2, OFF_CLEAR = 3;
  - ACTIVE_VALID_BIT = 7.
- Sub-module irq_arbiter: combinational select of req & mask with a start pointer; outputs grant_valid and grant_id. The pointer is tied to 0 when IRQ_CTRL_ROUND_ROBIN_EN is undefined.

## Test plan
- Timer path: pulse IRQ_IN[0] high and hold it → CPU_INTERRUPT_RAISE is 1 two cycles later. Then assert CPU_INTERRUPT_ACK → IRQ_ACK_OUT = 4'b0001 for exactly one cycle, and PENDING reads 0.
- Priority: raise IRQ_IN[3] and IRQ_IN[1] in the same cycle → ACTIVE_ID reads 8'h81 first. After the ack, it reads 8'h83.
  - With IRQ_CTRL_ROUND_ROBIN_EN and last-serviced id = 1, the same stimulus selects 3 first.
- Masking: write MASK = 8'hFE, then raise IRQ_IN[0] → no raise and PENDING = 8'h01. Write MASK = 8'hFF → raise asserts 1 cycle later.
- Set/clear collision: write CLEAR = 8'h02 in the same cycle a rising edge of IRQ_IN[1] is captured → PENDING bit 1 remains 1.
- Reset mid-operation: assert RESET while in ACTIVE with IRQ_IN[0] held high → after reset, raise is 0 and no ack is emitted. The next cycle recaptures the edge and raise returns 2 cycles later.
